// File: rtl/xoodoo_perm_nr.sv
// Xoodoo[nr] permutation core: 384-bit state with byte-masked absorb, domain injection,
// word readback, and RPC rounds per clock using the last nr round constants.
module xoodoo_perm_nr #(
    parameter int RPC = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        start_i,
    input  logic [3:0]  nr_i,
    input  logic [3:0]  word_idx_i,
    input  logic        word_we_i,
    input  logic [3:0]  word_be_i,
    input  logic [31:0] word_i,
    input  logic        dom_we_i,
    input  logic [31:0] dom_i,
    output logic [31:0] word_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t               fsm_q, fsm_d;
    logic [11:0][31:0]  st_q, st_d, wr_st, perm_st;
    logic [3:0]         rc_q, rc_d, base, rc_nxt;
    logic               done_q, done_d, err_q, err_d, nr_ok;
    logic [31:0]        be_mask;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [31:0] rc_of(input logic [4:0] idx);
        case (idx)
            5'd0:    return 32'h058;
            5'd1:    return 32'h038;
            5'd2:    return 32'h3C0;
            5'd3:    return 32'h0D0;
            5'd4:    return 32'h120;
            5'd5:    return 32'h014;
            5'd6:    return 32'h060;
            5'd7:    return 32'h02C;
            5'd8:    return 32'h380;
            5'd9:    return 32'h0F0;
            5'd10:   return 32'h1A0;
            5'd11:   return 32'h012;
            default: return 32'h000;
        endcase
    endfunction

    // Word i is plane i/4, lane i%4: theta, rho-west, iota, chi, rho-east
    function automatic logic [11:0][31:0] xoodoo_round(input logic [11:0][31:0] a,
                                                       input logic [31:0] rc);
        logic [3:0][31:0]  p, e;
        logic [11:0][31:0] t, c;
        for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[x+4] ^ a[x+8];
        for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
        for (int i = 0; i < 12; i++) t[i] = a[i] ^ e[i%4];
        for (int x = 0; x < 4; x++) begin
            c[x]   = t[x];
            c[x+4] = t[4 + (x+3)%4];
            c[x+8] = rotl(t[x+8], 11);
        end
        c[0] = c[0] ^ rc;
        for (int x = 0; x < 4; x++) begin
            t[x]   = c[x]   ^ (~c[x+4] & c[x+8]);
            t[x+4] = c[x+4] ^ (~c[x+8] & c[x]);
            t[x+8] = c[x+8] ^ (~c[x]   & c[x+4]);
        end
        for (int x = 0; x < 4; x++) begin
            a[x]   = t[x];
            a[x+4] = rotl(t[x+4], 1);
            a[x+8] = rotl(t[8 + (x+2)%4], 8);
        end
        return a;
    endfunction

    // In IDLE the first rounds start at 12-nr so the start edge already does work
    always_comb begin
        base    = (fsm_q == RUN) ? rc_q : (4'd12 - nr_i);
        perm_st = st_q;
        for (int r = 0; r < RPC; r++)
            perm_st = xoodoo_round(perm_st, rc_of(5'(base) + 5'(r)));
        rc_nxt  = base + 4'(RPC);
    end

    assign be_mask = {{8{word_be_i[3]}}, {8{word_be_i[2]}}, {8{word_be_i[1]}}, {8{word_be_i[0]}}};
    assign nr_ok   = (nr_i != 4'd0) && (nr_i <= 4'd12) && ((int'(nr_i) % RPC) == 0);

    always_comb begin
        wr_st = st_q;
        for (int i = 0; i < 12; i++)
            if (word_we_i && (word_idx_i == 4'(i))) wr_st[i] = wr_st[i] ^ (word_i & be_mask);
        if (dom_we_i) wr_st[11] = wr_st[11] ^ dom_i;
    end

    always_comb begin
        fsm_d  = fsm_q;
        st_d   = st_q;
        rc_d   = rc_q;
        done_d = 1'b0;
        err_d  = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (init_i) begin
                    st_d = '0;
                    rc_d = 4'd0;
                end else if (start_i) begin
                    if (nr_ok) begin
                        st_d = perm_st;
                        rc_d = rc_nxt;
                        if (rc_nxt == 4'd12) done_d = 1'b1;
                        else                 fsm_d  = RUN;
                    end else begin
                        err_d = 1'b1;
                        st_d  = wr_st;
                    end
                end else begin
                    st_d = wr_st;
                end
            end
            RUN: begin
                if (init_i) begin
                    st_d  = '0;
                    rc_d  = 4'd0;
                    fsm_d = IDLE;
                end else begin
                    st_d = perm_st;
                    rc_d = rc_nxt;
                    if (rc_nxt == 4'd12) begin
                        fsm_d  = IDLE;
                        done_d = 1'b1;
                    end
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fsm_q  <= IDLE;
            st_q   <= '0;
            rc_q   <= 4'd0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            rc_q   <= rc_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        word_o = 32'd0;
        for (int i = 0; i < 12; i++)
            if (word_idx_i == 4'(i)) word_o = st_q[i];
    end

    assign busy_o = (fsm_q == RUN);
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_xoodoo_perm_nr.sv
// Scoreboard bench for xoodoo_perm_nr: three instances (RPC = 2, 1, 3) share one
// stimulus bus gated by sel; expected states are queued at start and checked at done.
module tb_xoodoo_perm_nr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        init = 1'b0, start = 1'b0, word_we = 1'b0, dom_we = 1'b0;
    logic [3:0]  nr_in = 4'd0, word_idx = 4'd0, word_be = 4'd0;
    logic [31:0] word_in = 32'd0, dom_in = 32'd0;

    logic [31:0] wo [3];
    logic        busy_v [3], done_v [3], err_v [3];
    logic [31:0] wo_s;
    logic        busy_s, done_s, err_s;

    int          n_chk = 0, n_bad = 0;
    logic [383:0] model [3];
    logic [383:0] exp_q [$];
    int          rpc_tab [3] = '{2, 1, 3};
    logic [31:0] rc_tab [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                 32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

    always #20 clk = ~clk;

    xoodoo_perm_nr #(.RPC(2)) u_rpc2 (
        .clk_i(clk), .rst_i(rst_n), .init_i(init & (sel == 2'd0)), .start_i(start & (sel == 2'd0)),
        .nr_i(nr_in), .word_idx_i(word_idx), .word_we_i(word_we & (sel == 2'd0)), .word_be_i(word_be),
        .word_i(word_in), .dom_we_i(dom_we & (sel == 2'd0)), .dom_i(dom_in),
        .word_o(wo[0]), .busy_o(busy_v[0]), .done_o(done_v[0]), .err_o(err_v[0]));

    xoodoo_perm_nr #(.RPC(1)) u_rpc1 (
        .clk_i(clk), .rst_i(rst_n), .init_i(init & (sel == 2'd1)), .start_i(start & (sel == 2'd1)),
        .nr_i(nr_in), .word_idx_i(word_idx), .word_we_i(word_we & (sel == 2'd1)), .word_be_i(word_be),
        .word_i(word_in), .dom_we_i(dom_we & (sel == 2'd1)), .dom_i(dom_in),
        .word_o(wo[1]), .busy_o(busy_v[1]), .done_o(done_v[1]), .err_o(err_v[1]));

    xoodoo_perm_nr #(.RPC(3)) u_rpc3 (
        .clk_i(clk), .rst_i(rst_n), .init_i(init & (sel == 2'd2)), .start_i(start & (sel == 2'd2)),
        .nr_i(nr_in), .word_idx_i(word_idx), .word_we_i(word_we & (sel == 2'd2)), .word_be_i(word_be),
        .word_i(word_in), .dom_we_i(dom_we & (sel == 2'd2)), .dom_i(dom_in),
        .word_o(wo[2]), .busy_o(busy_v[2]), .done_o(done_v[2]), .err_o(err_v[2]));

    always_comb begin
        wo_s   = wo[sel];
        busy_s = busy_v[sel];
        done_s = done_v[sel];
        err_s  = err_v[sel];
    end

    // Reference model, written plane/lane-wise with a bitwise rotate
    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[(i + n) % 32] = v[i];
        return r;
    endfunction

    function automatic logic [383:0] m_round(input logic [383:0] s, input logic [31:0] rc);
        logic [31:0] a [3][4];
        logic [31:0] b [3][4];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [383:0] o;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] = s[32*(4*y+x) +: 32];
        for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
        for (int x = 0; x < 4; x++) e[x] = rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] ^= e[x];
        for (int x = 0; x < 4; x++) begin
            b[0][x] = a[0][x];
            b[1][x] = a[1][(x+3)%4];
            b[2][x] = rl(a[2][x], 11);
        end
        b[0][0] ^= rc;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) a[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
        for (int x = 0; x < 4; x++) begin
            o[32*x +: 32]     = a[0][x];
            o[32*(4+x) +: 32] = rl(a[1][x], 1);
            o[32*(8+x) +: 32] = rl(a[2][(x+2)%4], 8);
        end
        return o;
    endfunction

    function automatic logic [383:0] m_perm(input logic [383:0] s, input int nr);
        for (int i = 12 - nr; i < 12; i++) s = m_round(s, rc_tab[i]);
        return s;
    endfunction

    task automatic check_val(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_state(output logic [383:0] s);
        logic [3:0] save;
        save = word_idx;
        for (int i = 0; i < 12; i++) begin
            word_idx = 4'(i);
            #2;
            s[32*i +: 32] = wo_s;
        end
        word_idx = save;
    endtask

    task automatic check_state(input string tag);
        logic [383:0] s;
        read_state(s);
        check_val(tag, s, model[sel]);
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (idx < 12) model[sel][32*idx +: 32] ^= (d & m);
    endtask

    task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] be);
        word_idx = 4'(idx); word_in = d; word_be = be; word_we = 1'b1;
        model_write(idx, d, be);
        tick();
        word_we = 1'b0;
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        model[sel] = '0;
    endtask

    task automatic do_start(input int nr);
        logic [383:0] e;
        start = 1'b1;
        nr_in = 4'(nr);
        if (nr >= 1 && nr <= 12 && (nr % rpc_tab[sel]) == 0) begin
            e = m_perm(model[sel], nr);
            exp_q.push_back(e);
            model[sel] = e;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_busy);
        int cyc, bsy;
        logic [383:0] s, e;
        cyc = 0; bsy = 0;
        while (!done_s && cyc < 40) begin
            if (busy_s) bsy++;
            tick();
            cyc++;
        end
        check_val("done_seen", done_s, 1'b1);
        check_val("busy_cycles", bsy, exp_busy);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        if (done_s) begin
            read_state(s);
            check_val("perm_state", s, e);
        end
    endtask

    initial begin
        logic [383:0] s;
        for (int k = 0; k < 3; k++) model[k] = '0;

        // Reset state
        #30;
        check_val("rst_busy", busy_s, 1'b0);
        check_val("rst_done", done_s, 1'b0);
        check_val("rst_err", err_s, 1'b0);
        check_state("rst_state");
        rst_n = 1'b1;
        tick();

        // RPC=1: single round of the zero state
        sel = 2'd1;
        do_start(1);
        wait_done(0);
        word_idx = 4'd0; #2; check_val("r1_word0", wo_s, 32'h00000012);
        word_idx = 4'd4; #2; check_val("r1_word4", wo_s, 32'h00000024);
        word_idx = 4'd1; #2; check_val("r1_word1", wo_s, 32'h0);
        tick();
        check_val("r1_done_pulse", done_s, 1'b0);

        // RPC=2: masked writes, combined domain write, out-of-range index
        sel = 2'd0;
        wr(3, 32'hDEADBEEF, 4'b0101);
        word_idx = 4'd3; #2; check_val("be_word3", wo_s, 32'h00AD00EF);
        word_idx = 4'd11; word_in = 32'h000000FF; word_be = 4'hF; word_we = 1'b1;
        dom_in = 32'h01000000; dom_we = 1'b1;
        model_write(11, 32'h000000FF, 4'hF);
        model[sel][32*11 +: 32] ^= 32'h01000000;
        tick();
        word_we = 1'b0; dom_we = 1'b0;
        word_idx = 4'd11; #2; check_val("dom_word11", wo_s, 32'h010000FF);
        word_idx = 4'd12; #2; check_val("idx12_read", wo_s, 32'h0);
        wr(13, 32'hFFFFFFFF, 4'hF);
        check_state("idx13_ignored");

        // Xoodoo[12] of zero, then a back-to-back start in the done cycle
        do_init();
        check_state("init_zero");
        do_start(12);
        wait_done(5);
        do_start(12);
        wait_done(5);
        tick();
        check_val("done_one_cycle", done_s, 1'b0);

        // Illegal round counts; a write alongside the first is still applied
        word_idx = 4'd0; word_in = 32'h11223344; word_be = 4'hF; word_we = 1'b1;
        model_write(0, 32'h11223344, 4'hF);
        do_start(7);
        word_we = 1'b0;
        check_val("err_nr7", err_s, 1'b1);
        check_val("err_nr7_busy", busy_s, 1'b0);
        check_state("err_nr7_state");
        tick();
        check_val("err_pulse_end", err_s, 1'b0);
        do_start(0);
        check_val("err_nr0", err_s, 1'b1);
        do_start(13);
        check_val("err_nr13", err_s, 1'b1);
        check_val("err_nr13_busy", busy_s, 1'b0);
        check_state("err_state");
        do_start(6);
        wait_done(2);

        // Writes and starts while running are ignored
        do_start(12);
        word_idx = 4'd5; word_in = 32'hA5A5A5A5; word_be = 4'hF; word_we = 1'b1;
        dom_in = 32'h5A5A5A5A; dom_we = 1'b1; start = 1'b1; nr_in = 4'd7;
        tick();
        word_we = 1'b0; dom_we = 1'b0; start = 1'b0;
        check_val("run_no_err", err_s, 1'b0);
        wait_done(4);

        // RPC=3: init on the second busy cycle aborts without done
        sel = 2'd2;
        wr(2, 32'hCAFEF00D, 4'hF);
        do_start(12);
        tick();
        check_val("r3_busy2", busy_s, 1'b1);
        do_init();
        exp_q.delete();
        check_val("abort_busy", busy_s, 1'b0);
        check_val("abort_done", done_s, 1'b0);
        check_state("abort_state");
        tick();
        check_val("abort_no_done", done_s, 1'b0);
        do_start(12);
        wait_done(3);

        // Asynchronous reset mid-run, off the clock edge
        sel = 2'd0;
        wr(4, 32'h0F0F0F0F, 4'hF);
        do_start(12);
        tick();
        #10;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) model[k] = '0;
        exp_q.delete();
        check_val("arst_busy", busy_s, 1'b0);
        check_val("arst_done", done_s, 1'b0);
        check_val("arst_err", err_s, 1'b0);
        read_state(s);
        check_val("arst_state", s, 384'd0);
        rst_n = 1'b1;
        tick();
        check_val("arst_idle", busy_s, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
